// File: rtl/axil_mem_bridge.sv
// AXI4-Lite slave bridging host accesses onto a shared request/grant memory port.
// Define AXIL_BRIDGE_WSTRB_EN to honour write strobes; otherwise every write is full-word.
module axil_mem_bridge #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       MEM_WORDS = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_W-1:0]            s_axi_awaddr,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [DATA_W-1:0]            s_axi_wdata,
  input  logic [DATA_W/8-1:0]          s_axi_wstrb,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  input  logic [ADDR_W-1:0]            s_axi_araddr,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [DATA_W-1:0]            s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic [DATA_W/8-1:0]          mem_be,
  input  logic                         mem_gnt,
  input  logic [DATA_W-1:0]            mem_rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
  localparam int unsigned AW1    = ADDR_W + 1;
  localparam logic [ADDR_W:0] SPAN = AW1'(MEM_WORDS) << OFF_W;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, WR_MEM, RD_MEM, RD_DATA, WR_RESP, RD_RESP} state_t;

  state_t              state, state_n;
  logic                last_rd, last_rd_n;
  logic                aw_full, w_full, ar_full;
  logic                aw_full_n, w_full_n, ar_full_n;
  logic                aw_take, w_take, ar_take;
  logic [ADDR_W-1:0]   aw_addr, ar_addr;
  logic [DATA_W-1:0]   w_data;
  logic                mem_req_n, mem_we_n;
  logic [IDX_W-1:0]    mem_addr_n;
  logic [DATA_W-1:0]   mem_wdata_n;
  logic [STRB_W-1:0]   mem_be_n;
  logic                bvalid_n, rvalid_n;
  logic [1:0]          bresp_n, rresp_n;
  logic [DATA_W-1:0]   rdata_n;
  logic                aw_hs, w_hs, ar_hs;
  logic                wr_elig, rd_elig, pick_wr, pick_rd;
  logic                wr_bad, rd_bad, wr_nop;
  logic [IDX_W-1:0]    wr_idx, rd_idx;
  logic [STRB_W-1:0]   wr_be;

  // Out of window (below base or past the last word) or not word aligned.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return (a < BASE_ADDR) || ({1'b0, off} >= SPAN) || (a[OFF_W-1:0] != '0);
  endfunction

  assign aw_hs   = s_axi_awvalid && s_axi_awready;
  assign w_hs    = s_axi_wvalid  && s_axi_wready;
  assign ar_hs   = s_axi_arvalid && s_axi_arready;
  assign wr_elig = aw_full && w_full;
  assign rd_elig = ar_full;
  // Ties go to whichever type was not served last.
  assign pick_wr = wr_elig && (!rd_elig || last_rd);
  assign pick_rd = rd_elig && !pick_wr;
  assign wr_bad  = addr_bad(aw_addr);
  assign rd_bad  = addr_bad(ar_addr);
  assign wr_idx  = IDX_W'((aw_addr - BASE_ADDR) >> OFF_W);
  assign rd_idx  = IDX_W'((ar_addr - BASE_ADDR) >> OFF_W);

  assign aw_full_n = (aw_full && !aw_take) || aw_hs;
  assign w_full_n  = (w_full  && !w_take)  || w_hs;
  assign ar_full_n = (ar_full && !ar_take) || ar_hs;

`ifdef AXIL_BRIDGE_WSTRB_EN
  logic [STRB_W-1:0] w_strb;
  assign wr_be  = w_strb;
  assign wr_nop = (w_strb == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    w_strb <= '0;
    else if (w_hs) w_strb <= s_axi_wstrb;
  end
`else
  logic unused_wstrb;
  assign unused_wstrb = ^s_axi_wstrb;
  assign wr_be        = '1;
  assign wr_nop       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_rd       <= 1'b1;
      aw_full       <= 1'b0;
      w_full        <= 1'b0;
      ar_full       <= 1'b0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_arready <= 1'b0;
      aw_addr       <= '0;
      ar_addr       <= '0;
      w_data        <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_be        <= '0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= 2'b00;
      s_axi_rvalid  <= 1'b0;
      s_axi_rresp   <= 2'b00;
      s_axi_rdata   <= '0;
    end else begin
      state         <= state_n;
      last_rd       <= last_rd_n;
      aw_full       <= aw_full_n;
      w_full        <= w_full_n;
      ar_full       <= ar_full_n;
      s_axi_awready <= !aw_full_n;
      s_axi_wready  <= !w_full_n;
      s_axi_arready <= !ar_full_n;
      if (aw_hs) aw_addr <= s_axi_awaddr;
      if (ar_hs) ar_addr <= s_axi_araddr;
      if (w_hs)  w_data  <= s_axi_wdata;
      mem_req       <= mem_req_n;
      mem_we        <= mem_we_n;
      mem_addr      <= mem_addr_n;
      mem_wdata     <= mem_wdata_n;
      mem_be        <= mem_be_n;
      s_axi_bvalid  <= bvalid_n;
      s_axi_bresp   <= bresp_n;
      s_axi_rvalid  <= rvalid_n;
      s_axi_rresp   <= rresp_n;
      s_axi_rdata   <= rdata_n;
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_n     = state;
    last_rd_n   = last_rd;
    aw_take     = 1'b0;
    w_take      = 1'b0;
    ar_take     = 1'b0;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    mem_be_n    = mem_be;
    bvalid_n    = s_axi_bvalid;
    bresp_n     = s_axi_bresp;
    rvalid_n    = s_axi_rvalid;
    rresp_n     = s_axi_rresp;
    rdata_n     = s_axi_rdata;
    case (state)
      IDLE: begin
        if (pick_wr) begin
          aw_take   = 1'b1;
          w_take    = 1'b1;
          last_rd_n = 1'b0;
          if (wr_bad || wr_nop) begin
            state_n  = WR_RESP;
            bvalid_n = 1'b1;
            bresp_n  = wr_bad ? RESP_SLVERR : RESP_OKAY;
          end else begin
            state_n     = WR_MEM;
            mem_req_n   = 1'b1;
            mem_we_n    = 1'b1;
            mem_addr_n  = wr_idx;
            mem_wdata_n = w_data;
            mem_be_n    = wr_be;
          end
        end else if (pick_rd) begin
          ar_take   = 1'b1;
          last_rd_n = 1'b1;
          if (rd_bad) begin
            state_n  = RD_RESP;
            rvalid_n = 1'b1;
            rresp_n  = RESP_SLVERR;
            rdata_n  = '0;
          end else begin
            state_n    = RD_MEM;
            mem_req_n  = 1'b1;
            mem_we_n   = 1'b0;
            mem_addr_n = rd_idx;
          end
        end
      end
      WR_MEM: begin
        if (mem_gnt) begin
          state_n   = WR_RESP;
          mem_req_n = 1'b0;
          mem_we_n  = 1'b0;
          bvalid_n  = 1'b1;
          bresp_n   = RESP_OKAY;
        end
      end
      RD_MEM: begin
        if (mem_gnt) begin
          state_n   = RD_DATA;
          mem_req_n = 1'b0;
        end
      end
      RD_DATA: begin
        state_n  = RD_RESP;
        rdata_n  = mem_rdata;
        rresp_n  = RESP_OKAY;
        rvalid_n = 1'b1;
      end
      WR_RESP: begin
        if (s_axi_bready) begin
          state_n  = IDLE;
          bvalid_n = 1'b0;
        end
      end
      RD_RESP: begin
        if (s_axi_rready) begin
          state_n  = IDLE;
          rvalid_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axil_mem_bridge.sv
// Scoreboard bench for axil_mem_bridge: responses are recorded by a monitor and
// matched in order against expectations queued by each scenario task.
module tb_axil_mem_bridge;

  localparam int unsigned    DATA_W    = 32;
  localparam int unsigned    ADDR_W    = 32;
  localparam logic [31:0]    BASE      = 32'h1000_0000;
  localparam int unsigned    MEM_WORDS = 256;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          cyc;
  } rsp_t;

  logic        clk, rst_n;
  logic [31:0] awaddr, wdata, araddr, rdata, mem_wdata, mem_rdata;
  logic [3:0]  wstrb, mem_be;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic        mem_req, mem_we, mem_gnt, gnt_en;
  logic [7:0]  mem_addr;
  logic [31:0] tb_mem [MEM_WORDS];

  int   cyc_cnt = 0;
  int   req_cnt = 0;
  int   passed  = 0;
  int   total   = 0;
  rsp_t exp_b[$], exp_r[$], obs_b[$], obs_r[$];

  axil_mem_bridge #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .MEM_WORDS(MEM_WORDS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_gnt = gnt_en;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Memory behind the port: byte-masked writes, read data one cycle after grant.
  always @(posedge clk) begin
    if (mem_req) req_cnt <= req_cnt + 1;
    if (mem_req && mem_gnt) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) tb_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= tb_mem[mem_addr];
      end
    end
  end

  // Response monitor: records each B/R handshake with the cycle it was presented in.
  always @(posedge clk) begin
    if (rst_n && bvalid && bready) obs_b.push_back('{bresp, 32'h0, cyc_cnt});
    if (rst_n && rvalid && rready) obs_r.push_back('{rresp, rdata, cyc_cnt});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic drive(input logic aw_en, input logic w_en, input logic ar_en,
                       input logic [31:0] aw_a, input logic [31:0] wd,
                       input logic [3:0] ws, input logic [31:0] ar_a, output int t);
    awvalid = aw_en; awaddr = aw_a;
    wvalid  = w_en;  wdata  = wd; wstrb = ws;
    arvalid = ar_en; araddr = ar_a;
    t = -1;
    for (int i = 0; i < 64 && (awvalid || wvalid || arvalid); i++) begin
      logic ha, hw, hr;
      ha = awvalid && awready;
      hw = wvalid && wready;
      hr = arvalid && arready;
      cyc();
      if (ha) awvalid = 1'b0;
      if (hw) wvalid = 1'b0;
      if (hr) arvalid = 1'b0;
      if (ha || hw || hr) t = cyc_cnt;
    end
    if (awvalid || wvalid || arvalid) begin
      total++;
      $display("FAIL handshake_timeout aw=%b w=%b ar=%b", awvalid, wvalid, arvalid);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    end
  endtask

  task automatic wait_resp(input int nb, input int nr);
    for (int i = 0; i < 200 && (obs_b.size() < nb || obs_r.size() < nr); i++) cyc();
    if (obs_b.size() < nb || obs_r.size() < nr) begin
      total++;
      $display("FAIL resp_timeout got b=%0d r=%0d need b=%0d r=%0d",
               obs_b.size(), obs_r.size(), nb, nr);
    end
  endtask

  task automatic test_reset();
    repeat (3) cyc();
    total++; if (awready !== 1'b0) $display("FAIL rst_awready got %b exp 0", awready); else passed++;
    total++; if (wready  !== 1'b0) $display("FAIL rst_wready got %b exp 0", wready); else passed++;
    total++; if (arready !== 1'b0) $display("FAIL rst_arready got %b exp 0", arready); else passed++;
    total++; if (bvalid  !== 1'b0) $display("FAIL rst_bvalid got %b exp 0", bvalid); else passed++;
    total++; if (rvalid  !== 1'b0) $display("FAIL rst_rvalid got %b exp 0", rvalid); else passed++;
    total++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req got %b exp 0", mem_req); else passed++;
    total++; if (mem_we  !== 1'b0) $display("FAIL rst_mem_we got %b exp 0", mem_we); else passed++;
    total++; if (mem_addr !== 8'h0) $display("FAIL rst_mem_addr got %h exp 0", mem_addr); else passed++;
    total++; if (mem_be  !== 4'h0) $display("FAIL rst_mem_be got %h exp 0", mem_be); else passed++;
    total++; if (rdata !== 32'h0) $display("FAIL rst_rdata got %h exp 0", rdata); else passed++;
    total++; if ({bresp, rresp} !== 4'h0) $display("FAIL rst_resp got %b exp 0000", {bresp, rresp}); else passed++;
    rst_n = 1'b1;
    total++; if (awready !== 1'b0) $display("FAIL rel_awready_early got %b exp 0", awready); else passed++;
    cyc();
    total++; if ({awready, wready, arready} !== 3'b111)
      $display("FAIL rel_ready got %b exp 111", {awready, wready, arready}); else passed++;
  endtask

  task automatic test_write_read();
    int t;
    rsp_t e, o;
    drive(1'b1, 1'b1, 1'b0, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, t);
    exp_b.push_back('{2'b00, 32'h0, t + 2});
    cyc();
    total++; if ({mem_req, mem_we} !== 2'b11) $display("FAIL wr_req got %b exp 11", {mem_req, mem_we}); else passed++;
    total++; if (mem_addr !== 8'd4) $display("FAIL wr_mem_addr got %0d exp 4", mem_addr); else passed++;
    total++; if (mem_be !== 4'hF) $display("FAIL wr_mem_be got %h exp f", mem_be); else passed++;
    total++; if (mem_wdata !== 32'hDEAD_BEEF) $display("FAIL wr_mem_wdata got %h exp deadbeef", mem_wdata); else passed++;
    wait_resp(1, 0);
    e = exp_b.pop_front(); o = obs_b.pop_front();
    total++; if (o.resp !== e.resp) $display("FAIL wr_bresp got %b exp %b", o.resp, e.resp); else passed++;
    total++; if (o.cyc != e.cyc) $display("FAIL wr_bcycle got %0d exp %0d", o.cyc, e.cyc); else passed++;
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, BASE + 32'h10, t);
    exp_r.push_back('{2'b00, 32'hDEAD_BEEF, t + 3});
    cyc();
    total++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 8'd4})
      $display("FAIL rd_req got %b/%0d exp 10/4", {mem_req, mem_we}, mem_addr); else passed++;
    wait_resp(0, 1);
    e = exp_r.pop_front(); o = obs_r.pop_front();
    total++; if (o.resp !== e.resp) $display("FAIL rd_rresp got %b exp %b", o.resp, e.resp); else passed++;
    total++; if (o.data !== e.data) $display("FAIL rd_rdata got %h exp %h", o.data, e.data); else passed++;
    total++; if (o.cyc != e.cyc) $display("FAIL rd_rcycle got %0d exp %0d", o.cyc, e.cyc); else passed++;
  endtask

  task automatic test_w_early();
    int tw, t;
    rsp_t e, o;
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h1234_5678, 4'hF, 32'h0, tw);
    total++; if (wready !== 1'b0) $display("FAIL early_wready got %b exp 0", wready); else passed++;
    repeat (3) begin
      total++; if (mem_req !== 1'b0) $display("FAIL early_no_req got %b exp 0", mem_req); else passed++;
      cyc();
    end
    drive(1'b1, 1'b0, 1'b0, BASE + 32'h20, 32'h0, 4'h0, 32'h0, t);
    exp_b.push_back('{2'b00, 32'h0, t + 2});
    wait_resp(1, 0);
    e = exp_b.pop_front(); o = obs_b.pop_front();
    total++; if (o.resp !== e.resp) $display("FAIL early_bresp got %b exp %b", o.resp, e.resp); else passed++;
    total++; if (o.cyc != e.cyc) $display("FAIL early_bcycle got %0d exp %0d", o.cyc, e.cyc); else passed++;
    total++; if (tb_mem[8] !== 32'h1234_5678) $display("FAIL early_memword got %h exp 12345678", tb_mem[8]); else passed++;
  endtask

  task automatic test_errors();
    int t, r0;
    rsp_t e, o;
    r0 = req_cnt;
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, BASE + 32'(4 * MEM_WORDS), t);
    exp_r.push_back('{2'b10, 32'h0, t + 1});
    wait_resp(0, 1);
    e = exp_r.pop_front(); o = obs_r.pop_front();
    total++; if (o.resp !== e.resp) $display("FAIL err_rresp got %b exp %b", o.resp, e.resp); else passed++;
    total++; if (o.data !== e.data) $display("FAIL err_rdata got %h exp %h", o.data, e.data); else passed++;
    total++; if (o.cyc != e.cyc) $display("FAIL err_rcycle got %0d exp %0d", o.cyc, e.cyc); else passed++;
    drive(1'b1, 1'b1, 1'b0, BASE + 32'h2, 32'h5555_5555, 4'hF, 32'h0, t);
    exp_b.push_back('{2'b10, 32'h0, t + 1});
    drive(1'b1, 1'b1, 1'b0, BASE - 32'h4, 32'h6666_6666, 4'hF, 32'h0, t);
    exp_b.push_back('{2'b10, 32'h0, t + 1});
    wait_resp(2, 0);
    repeat (2) begin
      e = exp_b.pop_front(); o = obs_b.pop_front();
      total++; if (o.resp !== e.resp) $display("FAIL err_bresp got %b exp %b", o.resp, e.resp); else passed++;
      total++; if (o.cyc != e.cyc) $display("FAIL err_bcycle got %0d exp %0d", o.cyc, e.cyc); else passed++;
    end
    total++; if (req_cnt != r0) $display("FAIL err_no_req got %0d exp %0d", req_cnt, r0); else passed++;
  endtask

  task automatic test_stall();
    int t;
    rsp_t e, o;
    rready = 1'b0;
    gnt_en = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, BASE + 32'h10, t);
    cyc();
    repeat (5) begin
      total++; if ({mem_req, mem_addr} !== {1'b1, 8'd4})
        $display("FAIL stall_req got %b/%0d exp 1/4", mem_req, mem_addr); else passed++;
      cyc();
    end
    gnt_en = 1'b1;
    total++; if (mem_req !== 1'b1) $display("FAIL stall_req_last got %b exp 1", mem_req); else passed++;
    cyc();
    total++; if (rvalid !== 1'b0) $display("FAIL stall_rvalid_early got %b exp 0", rvalid); else passed++;
    cyc();
    total++; if (cyc_cnt != t + 8 || rvalid !== 1'b1)
      $display("FAIL stall_rvalid got %b at %0d exp 1 at %0d", rvalid, cyc_cnt, t + 8); else passed++;
    repeat (4) begin
      total++; if ({rvalid, rdata} !== {1'b1, 32'hDEAD_BEEF})
        $display("FAIL stall_hold got %b/%h exp 1/deadbeef", rvalid, rdata); else passed++;
      cyc();
    end
    exp_r.push_back('{2'b00, 32'hDEAD_BEEF, t + 12});
    rready = 1'b1;
    wait_resp(0, 1);
    e = exp_r.pop_front(); o = obs_r.pop_front();
    total++; if (o.data !== e.data) $display("FAIL stall_rdata got %h exp %h", o.data, e.data); else passed++;
    total++; if (o.cyc != e.cyc) $display("FAIL stall_rcycle got %0d exp %0d", o.cyc, e.cyc); else passed++;
  endtask

  task automatic test_strobe();
    int t;
    rsp_t e, o;
    logic [3:0]  be_exp;
    logic [31:0] rd_exp;
`ifdef AXIL_BRIDGE_WSTRB_EN
    int r0;
    be_exp = 4'b0010;
    rd_exp = 32'h0000_CC00;
`else
    be_exp = 4'hF;
    rd_exp = 32'hAABB_CCDD;
`endif
    drive(1'b1, 1'b1, 1'b0, BASE + 32'h40, 32'hAABB_CCDD, 4'b0010, 32'h0, t);
    exp_b.push_back('{2'b00, 32'h0, t + 2});
    cyc();
    total++; if (mem_be !== be_exp) $display("FAIL strb_mem_be got %b exp %b", mem_be, be_exp); else passed++;
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, BASE + 32'h40, t);
    exp_r.push_back('{2'b00, rd_exp, t + 3});
    wait_resp(1, 1);
    e = exp_b.pop_front(); o = obs_b.pop_front();
    total++; if (o.cyc != e.cyc) $display("FAIL strb_bcycle got %0d exp %0d", o.cyc, e.cyc); else passed++;
    e = exp_r.pop_front(); o = obs_r.pop_front();
    total++; if (o.data !== e.data) $display("FAIL strb_rdata got %h exp %h", o.data, e.data); else passed++;
`ifdef AXIL_BRIDGE_WSTRB_EN
    r0 = req_cnt;
    drive(1'b1, 1'b1, 1'b0, BASE + 32'h44, 32'h7777_7777, 4'h0, 32'h0, t);
    exp_b.push_back('{2'b00, 32'h0, t + 1});
    wait_resp(1, 0);
    e = exp_b.pop_front(); o = obs_b.pop_front();
    total++; if (o.resp !== e.resp) $display("FAIL strb0_bresp got %b exp %b", o.resp, e.resp); else passed++;
    total++; if (o.cyc != e.cyc) $display("FAIL strb0_bcycle got %0d exp %0d", o.cyc, e.cyc); else passed++;
    total++; if (req_cnt != r0) $display("FAIL strb0_no_req got %0d exp %0d", req_cnt, r0); else passed++;
`endif
  endtask

  task automatic test_tie();
    int t, t2;
    rsp_t e, o;
    apply_reset();
    drive(1'b1, 1'b1, 1'b1, BASE + 32'h30, 32'hA5A5_A5A5, 4'hF, BASE + 32'h30, t);
    drive(1'b1, 1'b1, 1'b0, BASE + 32'h34, 32'h5A5A_5A5A, 4'hF, 32'h0, t2);
    total++; if (t2 != t + 2) $display("FAIL tie_refill got %0d exp %0d", t2, t + 2); else passed++;
    exp_b.push_back('{2'b00, 32'h0, t + 2});
    exp_r.push_back('{2'b00, 32'hA5A5_A5A5, t + 6});
    exp_b.push_back('{2'b00, 32'h0, t + 9});
    wait_resp(2, 1);
    e = exp_b.pop_front(); o = obs_b.pop_front();
    total++; if (o.cyc != e.cyc) $display("FAIL tie_wr_first got %0d exp %0d", o.cyc, e.cyc); else passed++;
    e = exp_r.pop_front(); o = obs_r.pop_front();
    total++; if (o.data !== e.data) $display("FAIL tie_rdata got %h exp %h", o.data, e.data); else passed++;
    total++; if (o.cyc != e.cyc) $display("FAIL tie_rd_second got %0d exp %0d", o.cyc, e.cyc); else passed++;
    e = exp_b.pop_front(); o = obs_b.pop_front();
    total++; if (o.cyc != e.cyc) $display("FAIL tie_rd_wins_repeat got %0d exp %0d", o.cyc, e.cyc); else passed++;
  endtask

  task automatic test_reset_mid();
    int t;
    gnt_en = 1'b0;
    drive(1'b1, 1'b1, 1'b0, BASE + 32'h50, 32'h1111_1111, 4'hF, 32'h0, t);
    cyc();
    total++; if (mem_req !== 1'b1) $display("FAIL mid_req_before got %b exp 1", mem_req); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({mem_req, mem_we} !== 2'b00) $display("FAIL mid_req_cleared got %b exp 00", {mem_req, mem_we}); else passed++;
    gnt_en = 1'b1;
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (10) cyc();
    total++; if (obs_b.size() != 0 || bvalid !== 1'b0)
      $display("FAIL mid_no_bresp got %0d/%b exp 0/0", obs_b.size(), bvalid); else passed++;
    total++; if (tb_mem[20] !== 32'h0) $display("FAIL mid_no_write got %h exp 0", tb_mem[20]); else passed++;
  endtask

  initial begin
    for (int i = 0; i < int'(MEM_WORDS); i++) tb_mem[i] = 32'h0;
    mem_rdata = 32'h0;
    rst_n = 1'b0; gnt_en = 1'b1; bready = 1'b1; rready = 1'b1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    awaddr = 32'h0; wdata = 32'h0; wstrb = 4'h0; araddr = 32'h0;
    test_reset();
    test_write_read();
    test_w_early();
    test_errors();
    test_stall();
    test_strobe();
    test_tie();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axil_mem_bridge.md
# axil_mem_bridge

Parametrised AXI4-Lite slave that bridges host accesses onto a single-ported, request/grant memory port shared with the CPU core's data memory. It replaces the combinational pass-through slave. It provides:
- independent AW/W capture
- registered, back-pressure-correct B and R channels
- byte-strobe writes
- address range and alignment checking with SLVERR responses
- a fair write/read arbitration FSM

## Interface
Parameters:
- DATA_W, 32, AXI and memory data width; 32 or 64.
- ADDR_W, 32, AXI address width.
- BASE_ADDR, 32'h0000_0000, byte address of memory word 0.
- MEM_WORDS, 1024, number of DATA_W words behind the port; power of two.

Ports (reset is asynchronous and active-low; one clock):
- clk  in  1  sole clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- s_axi_awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  write address channel.
- s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  DATA_W/DATA_W/8/1/1  write data channel.
- s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
- s_axi_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  read address channel.
- s_axi_rdata/rresp/rvalid/rready  out/out/out/in  DATA_W/2/1/1  read data channel.
- mem_req  out  1  memory access request; held until mem_gnt.
- mem_we  out  1  1 = write, 0 = read; valid with mem_req.
- mem_addr  out  $clog2(MEM_WORDS)  word index.
- mem_wdata  out  DATA_W  write data.
- mem_be  out  DATA_W/8  byte enables.
- mem_gnt  in  1  request accepted this cycle; the CPU may hold it low.
- mem_rdata  in  DATA_W  read data, valid the cycle after a read grant.

## Operation
- AW, W and AR each have a one-entry holding register.
- awready, wready and arready are registered and equal "holding register empty".
- A handshake (valid & ready at an edge) fills the register; it empties when the FSM launches that transaction.
- Write is eligible when both AW and W are held. Read is eligible when AR is held.
- One transaction outstanding at a time.
- FSM states: IDLE, WR_MEM, RD_MEM, RD_DATA, WR_RESP, RD_RESP.
- IDLE:
  - Only write eligible → WR_MEM. Only read eligible → RD_MEM.
  - Both eligible → the type not served last goes first. After reset the last-served type is "read", so write wins the first tie.
  - On entry, check the address. Error if addr < BASE_ADDR, or offset ≥ MEM_WORDS·DATA_W/8, or addr[log2(DATA_W/8)-1:0] ≠ 0.
  - On error, skip the memory state: go to WR_RESP or RD_RESP with resp 2'b10 (SLVERR), rdata 0, no mem_req.
- WR_MEM / RD_MEM:
  - mem_req = 1; mem_addr = (addr − BASE_ADDR) >> log2(DATA_W/8).
  - Stay until mem_gnt. Write → WR_RESP; read → RD_DATA.
- RD_DATA: capture mem_rdata into the rdata register, rresp 2'b00 → RD_RESP.
- WR_RESP: bvalid = 1, held with bresp stable until bready → IDLE.
- RD_RESP: rvalid = 1, held with rdata/rresp stable until rready → IDLE.
- Simultaneous events:
  - A new AW/W/AR handshake in the same cycle the FSM consumes a holding register is legal. Consume and refill occur on that edge.
  - Handshakes into a full register cannot happen because ready is low.
- Reset mid-transaction:
  - All state clears immediately, including mem_req.
  - Any in-flight grant is ignored; no response is ever issued for it.

## Timing
Reset values:
- awready, wready, arready: 0; each goes to 1 at the first edge after rst_n deasserts.
- bvalid, rvalid, mem_req, mem_we: 0.
- bresp, rresp, rdata, mem_addr, mem_wdata, mem_be: 0.
- FSM: IDLE.

Latency with mem_gnt tied high (AW/W handshake at edge T, bready/rready high):
- Write: mem_req during T→T+1; bvalid high in cycle T+2 (edge T+1 → T+2).
- Read: mem_req in cycle T+1; rvalid high in cycle T+3.
- Error responses: bvalid or rvalid in cycle T+1 after the handshake (T = the edge where the transaction became eligible).
- Each cycle mem_gnt is low adds one cycle of latency.
- Back-to-back throughput: one transaction per 3 cycles (write) or 4 cycles (read).

## Configuration
- AXIL_BRIDGE_WSTRB_EN defined:
  - mem_be = captured wstrb.
  - A write with wstrb == 0 completes with OKAY and issues no mem_req.
- AXIL_BRIDGE_WSTRB_EN undefined:
  - wstrb is ignored and mem_be = all ones.
  - Every in-range write is a full-word write.

## Test plan
- Write 0xDEADBEEF to BASE_ADDR+0x10 (wstrb 4'hF), then read it back:
  - mem_addr = 4, mem_be = 4'hF.
  - bresp 00 in cycle T+2; rdata 0xDEADBEEF, rresp 00.
- W valid 3 cycles before AW:
  - wready drops after the W handshake; no mem_req until AW arrives.
  - bvalid 2 cycles after the AW handshake.
- Error accesses:
  - Read at BASE_ADDR + 4·MEM_WORDS → rresp 10, rdata 0, mem_req never asserted.
  - Write at BASE_ADDR+0x2 → bresp 10.
- AW+W and AR valid in the same cycle after reset:
  - Write served first, read second.
  - Repeat the tie: read served first.
- mem_gnt held low 5 cycles during a read → mem_req and mem_addr stable throughout; rvalid in cycle T+8. Then rready held low 4 cycles → rvalid and rdata stable.
- Byte strobes:
  - With the macro defined, wstrb 4'b0010 → mem_be 4'b0010.
  - Without the macro → mem_be 4'hF.
  - Separately, assert rst_n low while in WR_MEM → mem_req 0 immediately, bvalid never rises.
